// File: rtl/alu_pkg.sv
// Shared ALU definitions: the operation encoding seen on the ALU_Control bus
// and the command driver's FSM state type.
package alu_pkg;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_OR  = 2'b11
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETTLE = 2'b01,
      RESP   = 2'b10
   } state_t;

endpackage

// File: rtl/alu_cmd_driver.sv
// Command-side initiator for an external combinational ALU: registers one
// operation at a time onto the ALU inputs, waits for it to settle, then returns the result.
module alu_cmd_driver
   import alu_pkg::*;
#(
   parameter int WIDTH         = 32,
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic [WIDTH-1:0] src_a,
   output logic [WIDTH-1:0] src_b,
   output logic [1:0]       ALU_Control,
   input  logic [WIDTH-1:0] ALU_out,
   input  logic             zero,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             busy,
   output logic [CNT_W-1:0] op_count,
   output logic             zero_mismatch
);

   localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SC_W-1:0] SC_INIT = SC_W'(SETTLE_CYCLES - 1);

   state_t          state;
   logic [SC_W-1:0] cnt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign cmd_ready = (state == IDLE) && !reset;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         src_a         <= '0;
         src_b         <= '0;
         ALU_Control   <= ALU_ADD;
         rsp_valid     <= 1'b0;
         rsp_result    <= '0;
         rsp_zero      <= 1'b0;
         op_count      <= '0;
         zero_mismatch <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  src_a       <= cmd_a;
                  src_b       <= cmd_b;
                  ALU_Control <= cmd_op;
                  cnt         <= SC_INIT;
                  state       <= SETTLE;
               end
            end
            // ALU inputs are stable here; sample once the settle budget runs out
            SETTLE: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  rsp_result <= ALU_out;
                  rsp_zero   <= zero;
                  rsp_valid  <= 1'b1;
                  if (zero != (ALU_out == '0))
                     zero_mismatch <= 1'b1;
                  state <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  op_count  <= sat_inc(op_count);
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
Command-side initiator for the combinational ALU: accepts operation requests on a valid/ready command channel and drives the ALU's src_a, src_b and ALU_Control inputs. It waits a configurable settle time, captures ALU_out and zero, and returns them on a valid/ready response channel. It sits between the control path or interconnect front end and the ALU, and serialises operations one at a time. It also keeps an operation counter and a zero-flag consistency check.

Parameters:
WIDTH, 32, data width of operands and result; must match the attached ALU instance.
SETTLE_CYCLES, 1, cycles operands are held before capture (>=1); larger values cover long or retimed ALU paths.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_op  in  2  operation code (alu_op_t)
cmd_a  in  WIDTH  operand A
cmd_b  in  WIDTH  operand B
src_a  out  WIDTH  registered operand A to ALU
src_b  out  WIDTH  registered operand B to ALU
ALU_Control  out  2  registered op code to ALU
ALU_out  in  WIDTH  ALU result
zero  in  1  ALU zero flag
rsp_valid  out  1  result present
rsp_ready  in  1  consumer accepts result
rsp_result  out  WIDTH  captured ALU_out
rsp_zero  out  1  captured zero
busy  out  1  high in SETTLE or RESP
op_count  out  CNT_W  completed responses, saturating
zero_mismatch  out  1  sticky: captured zero != (ALU_out == 0)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Op encoding, fixed: 00 ADD, 01 SUB (A-B), 10 AND, 11 OR.
- Reset values: src_a=0, src_b=0, ALU_Control=00, rsp_valid=0, rsp_result=0, rsp_zero=0, op_count=0, zero_mismatch=0, state=IDLE, settle counter=0. cmd_ready is forced 0 while reset is high.
- FSM states are IDLE, SETTLE and RESP.
- IDLE:
  - cmd_ready=1, busy=0.
  - On cmd_valid, at edge k: load src_a<=cmd_a, src_b<=cmd_b, ALU_Control<=cmd_op, load cnt<=SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - cmd_ready=0, busy=1.
  - If cnt!=0: decrement.
  - If cnt==0: capture rsp_result<=ALU_out, rsp_zero<=zero, set rsp_valid<=1, go to RESP.
  - Capture occurs at edge k+SETTLE_CYCLES; rsp_valid is visible in the cycle after that edge.
- RESP:
  - cmd_ready=0, busy=1.
  - rsp_valid, rsp_result and rsp_zero hold stable until the rsp_ready handshake.
  - On rsp_valid&&rsp_ready: rsp_valid<=0; op_count increments, saturating at 2^CNT_W-1; go to IDLE.
- No overlap: a new command is accepted at the earliest one cycle after the response handshake. Minimum period is SETTLE_CYCLES+2 cycles per op.
- src_a, src_b and ALU_Control hold their last values after capture until the next accepted command, so the ALU inputs stay quiet.
- rsp_result and rsp_zero hold their last values after the handshake.
- zero_mismatch is set at capture if zero != (ALU_out=={WIDTH{1'b0}}). It is cleared only by reset.
- Reset mid-operation (SETTLE or RESP): the in-flight op is discarded, nothing is emitted, and all registers return to reset values the next cycle.
- cmd_valid while not in IDLE is ignored; the command is not consumed.
- rsp_ready while rsp_valid=0 has no effect.

Decomposition:
- Shared package alu_pkg:
  - typedef enum logic [1:0] alu_op_t {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR}.
  - typedef enum state_t {IDLE, SETTLE, RESP}.
  - No sub-module; the ALU stays an external peer and the bench instantiates ALU #(WIDTH) beside the driver.

Test Plan:
1. WIDTH=8, SETTLE_CYCLES=1, rsp_ready=1; send ADD a=5 b=3 -> src_a=5, src_b=3, ALU_Control=00 one cycle after accept; rsp_valid two cycles after accept; rsp_result=8, rsp_zero=0; op_count=1.
2. SUB a=7 b=7 -> rsp_result=0, rsp_zero=1. Then AND 0xF0,0x0F -> 0x00 with zero=1. Then OR 0xF0,0x0F -> 0xFF with zero=0. Final op_count=3, zero_mismatch=0.
3. Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid and data stable throughout; cmd_ready=0; a pending cmd_valid is not consumed. Release -> handshake, then the pending command is accepted on the next cycle.
4. SETTLE_CYCLES=3 -> capture at edge k+3. An ALU stub that changes ALU_out at k+2 must have its k+3 value captured.
5. CNT_W=2; run 5 ops -> op_count sequence 1,2,3,3,3.
6. Reset in SETTLE, and separately in RESP:
   - Stub ALU reporting zero=1 with ALU_out=4 -> zero_mismatch=1 sticky.
   - Reset -> next cycle rsp_valid=0, src_a=0, op_count=0, zero_mismatch=0, cmd_ready=1 after reset deasserts.
